// File: rtl/packet_arbiter_pkg.sv
// Shared types for the router output-port packet arbiter.
// AXI-Stream bundles, routing header TID and arbiter FSM states.
package packet_arbiter_pkg;

  localparam int TID_W       = 4;
  localparam int PAYLOAD_W   = 16;
  localparam int MISO_DATA_W = 8;

  localparam logic [TID_W-1:0] ROUTING_HEADER = 4'hF;

  typedef struct packed {
    logic [TID_W-1:0]     TID;
    logic                 TLAST;
    logic [PAYLOAD_W-1:0] payload;
  } axis_data_t;

  typedef struct packed {
    logic       TVALID;
    axis_data_t data;
  } axis_mosi_t;

  typedef struct packed {
    logic                   TREADY;
    logic [MISO_DATA_W-1:0] data;
  } axis_miso_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_t;

  // A valid flit that opens a new packet
  function automatic logic is_header(axis_mosi_t f);
    return f.TVALID && (f.data.TID == ROUTING_HEADER);
  endfunction

endpackage

// File: rtl/packet_arbiter_skid.sv
// Generic 2-entry AXI-Stream register slice.
// Upstream ready is a flop, so downstream ready never reaches it combinationally.
module axis_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             s_valid_i,
  input  logic [WIDTH-1:0] s_data_i,
  output logic             s_ready_o,
  output logic             m_valid_o,
  output logic [WIDTH-1:0] m_data_o,
  input  logic             m_ready_i
);

  logic [1:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             ready_q, ready_d;
  logic             push, pop;

  assign push      = s_valid_i && ready_q;
  assign pop       = m_ready_i && (cnt_q != 2'd0);
  assign s_ready_o = ready_q;
  assign m_valid_o = (cnt_q != 2'd0);
  assign m_data_o  = head_q;

  // Head is always the oldest entry; tail only holds the overflow flit
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = s_data_i;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s_data_i;
        end else if (push) begin
          tail_d = s_data_i;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
    ready_d = (cnt_d != 2'd2);
  end

  // Storage, occupancy and registered upstream ready
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q   <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/packet_arbiter.sv
// Round-robin packet merge for one router output port.
// Grant is taken on a header flit and held through the TLAST flit.
module packet_arbiter
  import packet_arbiter_pkg::*;
#(
  parameter int CHANNEL_NUMBER       = 5,
  parameter int CHANNEL_NUMBER_WIDTH = $clog2(CHANNEL_NUMBER)
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  axis_mosi_t in_mosi_i [CHANNEL_NUMBER],
  output axis_miso_t in_miso_o [CHANNEL_NUMBER],
  output axis_mosi_t out_mosi_o,
  input  axis_miso_t out_miso_i
);

  typedef logic [CHANNEL_NUMBER_WIDTH-1:0] ch_idx_t;

  localparam ch_idx_t LAST_CH = ch_idx_t'(CHANNEL_NUMBER - 1);

  arb_state_t state_q, state_d;
  ch_idx_t    grant_q, grant_d;
  ch_idx_t    rr_ptr_q, rr_ptr_d;
  ch_idx_t    sel;
  ch_idx_t    chan;
  logic       sel_vld;
  logic       chan_vld;
  logic       push_vld;
  logic       xfer;
  logic       skid_ready;
  logic       skid_valid;
  axis_data_t push_data;
  axis_data_t skid_data;
  int         idx;

  logic [CHANNEL_NUMBER-1:0] req;
  logic [CHANNEL_NUMBER-1:0] chan_hit;

  // Header requests per channel
  always_comb begin
    req = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      req[i] = is_header(in_mosi_i[i]);
    end
  end

  // Round-robin search starting at rr_ptr, wrapping
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    idx     = 0;
    for (int k = 0; k < CHANNEL_NUMBER; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= CHANNEL_NUMBER) begin
        idx = idx - CHANNEL_NUMBER;
      end
      if (!sel_vld && req[idx]) begin
        sel     = ch_idx_t'(idx);
        sel_vld = 1'b1;
      end
    end
  end

  // Active channel: the locked grant, else the RR winner
  always_comb begin
    chan     = (state_q == ARB_LOCKED) ? grant_q : sel;
    chan_vld = (state_q == ARB_LOCKED) || sel_vld;
    chan_hit = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      chan_hit[i] = chan_vld && (chan == ch_idx_t'(i));
    end
  end

  // Forward the active channel's flit into the skid
  always_comb begin
    push_vld  = 1'b0;
    push_data = '0;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (chan_hit[i]) begin
        push_vld  = in_mosi_i[i].TVALID;
        push_data = in_mosi_i[i].data;
      end
    end
  end

  assign xfer = push_vld && skid_ready;

  // Ready and back-channel data only toward the active channel
  always_comb begin
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      in_miso_o[i].TREADY = chan_hit[i] && skid_ready;
      in_miso_o[i].data   = chan_hit[i] ? out_miso_i.data : '0;
    end
  end

  // Grant on header, hold until the tail flit moves
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (xfer) begin
          grant_d  = sel;
          rr_ptr_d = (sel == LAST_CH) ? '0 : ch_idx_t'(sel + 1'b1);
          if (!push_data.TLAST) begin
            state_d = ARB_LOCKED;
          end
        end
      end
      ARB_LOCKED: begin
        if (xfer && push_data.TLAST) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state, grant and round-robin pointer
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= ARB_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  axis_skid_buffer #(
    .WIDTH($bits(axis_data_t))
  ) u_skid (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .s_valid_i(push_vld),
    .s_data_i (push_data),
    .s_ready_o(skid_ready),
    .m_valid_o(skid_valid),
    .m_data_o (skid_data),
    .m_ready_i(out_miso_i.TREADY)
  );

  assign out_mosi_o = {skid_valid, skid_data};

endmodule

// File: tb/tb_packet_arbiter.sv
// Directed bench for packet_arbiter with N=5.
// Cycle table for selection/lock, scripted sources for multi-cycle cases.
module tb_packet_arbiter;
  import packet_arbiter_pkg::*;

  localparam int N = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  axis_mosi_t in_mosi [N];
  axis_miso_t in_miso [N];
  axis_mosi_t out_mosi;
  axis_miso_t out_miso;

  always #5 clk = ~clk;

  packet_arbiter #(.CHANNEL_NUMBER(N)) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .in_mosi_i (in_mosi),
    .in_miso_o (in_miso),
    .out_mosi_o(out_mosi),
    .out_miso_i(out_miso)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] rdy_vec();
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = in_miso[i].TREADY;
    return r;
  endfunction

  // ---------------- cycle table ----------------
  typedef struct packed {
    logic [4:0]  vld;
    logic [4:0]  hdr;
    logic [4:0]  last;
    logic        ordy;
    logic [4:0]  rdy;
    logic        ov;
    logic [15:0] pay;
    logic [2:0]  rr;
    logic        lk;
  } vec_t;

  vec_t tbl [11];

  // ---------------- scripted sources ----------------
  axis_data_t src_mem [N][8];
  int src_len [N];
  int src_idx [N];
  int src_start [N];
  int xcyc [N][8];
  int first_rdy [N];
  axis_data_t got [32];
  int got_cyc [32];
  int ngot, cyc, lo_start, lo_len;
  int pushes, inflight_max, stable_err;
  logic hold_prev;
  axis_data_t prev_data;

  function automatic axis_data_t mkflit(int ch, int k, logic [3:0] tid,
                                        logic last);
    axis_data_t f;
    logic [3:0] c4, k4;
    c4 = ch[3:0];
    k4 = k[3:0];
    f.TID     = tid;
    f.TLAST   = last;
    f.payload = {c4, k4, 8'hC3};
    return f;
  endfunction

  task automatic clear_src();
    for (int ch = 0; ch < N; ch++) begin
      src_len[ch]   = 0;
      src_idx[ch]   = 0;
      src_start[ch] = 0;
      first_rdy[ch] = -1;
      for (int k = 0; k < 8; k++) xcyc[ch][k] = -1;
    end
    ngot = 0; cyc = 0; lo_start = 0; lo_len = 0;
    pushes = 0; inflight_max = 0; stable_err = 0;
    hold_prev = 1'b0; prev_data = '0;
  endtask

  task automatic add_pkt(int ch, int nf, int start);
    for (int k = 0; k < nf; k++) begin
      src_mem[ch][k] = mkflit(ch, k, (k == 0) ? ROUTING_HEADER : 4'h1,
                              k == nf - 1);
    end
    src_len[ch]   = nf;
    src_start[ch] = start;
  endtask

  task automatic drive();
    for (int ch = 0; ch < N; ch++) begin
      in_mosi[ch].TVALID = (src_idx[ch] < src_len[ch]) && (cyc >= src_start[ch]);
      in_mosi[ch].data   = in_mosi[ch].TVALID ? src_mem[ch][src_idx[ch]] : '0;
    end
    out_miso.TREADY = !(lo_len > 0 && cyc >= lo_start && cyc < lo_start + lo_len);
    out_miso.data   = 8'h5A;
  endtask

  task automatic step();
    logic adv [N];
    @(negedge clk);
    for (int ch = 0; ch < N; ch++) begin
      adv[ch] = in_mosi[ch].TVALID && in_miso[ch].TREADY;
      if (in_miso[ch].TREADY && first_rdy[ch] < 0) first_rdy[ch] = cyc;
      if (adv[ch]) begin
        xcyc[ch][src_idx[ch]] = cyc;
        pushes++;
      end
    end
    if (hold_prev && (!out_mosi.TVALID || out_mosi.data !== prev_data))
      stable_err++;
    hold_prev = out_mosi.TVALID && !out_miso.TREADY;
    prev_data = out_mosi.data;
    if (out_mosi.TVALID && out_miso.TREADY && ngot < 32) begin
      got[ngot]     = out_mosi.data;
      got_cyc[ngot] = cyc;
      ngot++;
    end
    if (pushes - ngot > inflight_max) inflight_max = pushes - ngot;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < N; ch++) if (adv[ch]) src_idx[ch]++;
    cyc++;
    drive();
  endtask

  // Run until the expected flit count is out, then a few idle cycles
  task automatic run(int exp_flits, int budget, string name);
    int b;
    b = budget;
    drive();
    while (ngot < exp_flits && b > 0) begin
      step();
      b--;
    end
    repeat (3) step();
    chk(name, ngot, exp_flits);
  endtask

  // Compare output order against a list of (channel, flit) pairs
  function automatic int order_errs(int chs[$], int nfl);
    int e, p;
    e = 0;
    p = 0;
    foreach (chs[j]) begin
      for (int k = 0; k < nfl; k++) begin
        if (p >= ngot || got[p] !== src_mem[chs[j]][k]) e++;
        p++;
      end
    end
    return e;
  endfunction

  task automatic idle_inputs();
    for (int ch = 0; ch < N; ch++) in_mosi[ch] = '0;
    out_miso.TREADY = 1'b1;
    out_miso.data   = 8'h5A;
  endtask

  task automatic do_reset(logic check);
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (check) begin
      chk("rst_out_valid", out_mosi.TVALID, 1'b0);
      chk("rst_out_data", out_mosi.data, '0);
      chk("rst_in_ready", rdy_vec(), 5'b0);
      chk("rst_rr_ptr", dut.rr_ptr_q, 3'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clear_src();
  endtask

  initial begin
    int ordr[$];

    idle_inputs();
    #1;

    // ---- Test 1: reset, first header on ch2 ----
    do_reset(1'b1);
    add_pkt(2, 2, 0);
    run(2, 20, "t1_count");
    chk("t1_accept_cyc", xcyc[2][0], 0);
    chk("t1_latency", got_cyc[0], xcyc[2][0] + 1);
    chk("t1_first_flit", got[0], src_mem[2][0]);
    chk("t1_grant", dut.grant_q, 3'd2);
    chk("t1_rr_ptr", dut.rr_ptr_q, 3'd3);
    chk("t1_state", dut.state_q, ARB_IDLE);

    // ---- Cycle table: single-flit packets, wrap, lock ----
    tbl[0]  = '{5'b00101, 5'b00101, 5'b00101, 1'b1, 5'b00001, 1'b0, 16'h0000, 3'd0, 1'b0};
    tbl[1]  = '{5'b00100, 5'b00100, 5'b00100, 1'b1, 5'b00100, 1'b1, 16'h0000, 3'd1, 1'b0};
    tbl[2]  = '{5'b00011, 5'b00010, 5'b00000, 1'b1, 5'b00010, 1'b1, 16'h0102, 3'd3, 1'b0};
    tbl[3]  = '{5'b01001, 5'b01000, 5'b00000, 1'b1, 5'b00010, 1'b1, 16'h0201, 3'd2, 1'b1};
    tbl[4]  = '{5'b01010, 5'b01010, 5'b00010, 1'b1, 5'b00010, 1'b0, 16'h0000, 3'd2, 1'b1};
    tbl[5]  = '{5'b01001, 5'b01000, 5'b01000, 1'b1, 5'b01000, 1'b1, 16'h0401, 3'd2, 1'b0};
    tbl[6]  = '{5'b10001, 5'b10001, 5'b10001, 1'b1, 5'b10000, 1'b1, 16'h0503, 3'd4, 1'b0};
    tbl[7]  = '{5'b00001, 5'b00001, 5'b00001, 1'b1, 5'b00001, 1'b1, 16'h0604, 3'd0, 1'b0};
    tbl[8]  = '{5'b00000, 5'b00000, 5'b00000, 1'b0, 5'b00000, 1'b1, 16'h0700, 3'd1, 1'b0};
    tbl[9]  = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b1, 16'h0700, 3'd1, 1'b0};
    tbl[10] = '{5'b00000, 5'b00000, 5'b00000, 1'b1, 5'b00000, 1'b0, 16'h0000, 3'd1, 1'b0};

    do_reset(1'b0);
    for (int s = 0; s < 11; s++) begin
      logic [7:0] s8;
      s8 = s[7:0];
      for (int ch = 0; ch < N; ch++) begin
        logic [7:0] c8;
        c8 = ch[7:0];
        in_mosi[ch].TVALID       = tbl[s].vld[ch];
        in_mosi[ch].data.TID     = tbl[s].hdr[ch] ? ROUTING_HEADER : 4'h1;
        in_mosi[ch].data.TLAST   = tbl[s].last[ch];
        in_mosi[ch].data.payload = {s8, c8};
      end
      out_miso.TREADY = tbl[s].ordy;
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", s), rdy_vec(), tbl[s].rdy);
      chk($sformatf("tbl%0d_out_valid", s), out_mosi.TVALID, tbl[s].ov);
      if (tbl[s].ov)
        chk($sformatf("tbl%0d_out_payload", s), out_mosi.data.payload, tbl[s].pay);
      chk($sformatf("tbl%0d_rr_ptr", s), dut.rr_ptr_q, tbl[s].rr);
      chk($sformatf("tbl%0d_locked", s), dut.state_q == ARB_LOCKED, tbl[s].lk);
      @(posedge clk);
      #1;
    end

    // ---- Test 2: contention on ch0,1,3,4 ----
    do_reset(1'b0);
    add_pkt(0, 3, 0);
    add_pkt(1, 3, 0);
    add_pkt(3, 3, 0);
    add_pkt(4, 3, 0);
    run(12, 60, "t2_count");
    ordr = '{0, 1, 3, 4};
    chk("t2_order", order_errs(ordr, 3), 0);
    chk("t2_latency", got_cyc[0], 1);
    chk("t2_back_to_back", got_cyc[11] - got_cyc[0], 11);

    // ---- Test 3: header on ch4 waits for ch1 tail ----
    do_reset(1'b0);
    add_pkt(1, 4, 0);
    add_pkt(4, 2, 2);
    run(6, 40, "t3_count");
    ordr = '{1};
    chk("t3_ch1_first", order_errs(ordr, 4), 0);
    chk("t3_ch4_after", got[4], src_mem[4][0]);
    chk("t3_ch4_first_ready", first_rdy[4], xcyc[1][3] + 1);
    chk("t3_ch4_grant_cyc", xcyc[4][0], xcyc[1][3] + 1);
    chk("t3_rr_ptr", dut.rr_ptr_q, 3'd0);

    // ---- Test 4: output backpressure mid-packet ----
    do_reset(1'b0);
    add_pkt(2, 6, 0);
    lo_start = 3;
    lo_len   = 5;
    begin
      int rdy_hi;
      int b;
      rdy_hi = 0;
      b = 40;
      drive();
      while (ngot < 6 && b > 0) begin
        if (cyc > lo_start && cyc < lo_start + lo_len && in_miso[2].TREADY)
          rdy_hi++;
        step();
        b--;
      end
      repeat (3) step();
      chk("t4_count", ngot, 6);
      chk("t4_ready_low", rdy_hi, 0);
    end
    ordr = '{2};
    chk("t4_order", order_errs(ordr, 6), 0);
    chk("t4_inflight_max", inflight_max, 2);
    chk("t4_stable", stable_err, 0);

    // ---- Test 6: reset mid-packet on ch3 ----
    do_reset(1'b0);
    add_pkt(3, 4, 0);
    drive();
    step();
    step();
    chk("t6_mid_pkt", dut.state_q, ARB_LOCKED);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_out_valid", out_mosi.TVALID, 1'b0);
    chk("t6_rst_in_ready", rdy_vec(), 5'b0);
    chk("t6_rst_state", dut.state_q, ARB_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    clear_src();
    src_mem[3][0] = mkflit(3, 5, 4'h1, 1'b0);
    src_len[3] = 1;
    drive();
    repeat (4) step();
    chk("t6_nonhdr_ready", first_rdy[3], -1);
    chk("t6_nonhdr_out", ngot, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
